// File: rtl/data_mem_io_if.sv
// CPU data-port address/direction bundle; DD stays a module-level inout.
interface data_mem_io_if;
    logic [15:0] DA;
    logic        RW;

    modport master (output DA, output RW);
    modport slave  (input  DA, input  RW);
endinterface

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped I/O (output latch, synchronised input,
// prescaled timer with sticky overflow, byte UART transmitter).
module data_mem_io #(
    parameter int AW           = 8,
    parameter int TIMER_DIV    = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          CK,
    input  logic          RST,
    data_mem_io_if.slave  bus,
    inout  wire  [15:0]   DD,
    input  logic [15:0]   PIN,
    output logic [15:0]   POUT,
    output logic          TXD
);
    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ust_e;

    logic [15:0] mem [2**AW];
    logic [15:0] pout_q, sync1_q, sync2_q, tcnt_q, tcnt_d, rdata;
    logic [PW-1:0] pre_q, pre_d;
    logic        ovf_q, ovf_d;
    ust_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        busy;

    // Address decode: I/O requires DA[14:3]==0, RAM aliases on upper bits
    logic       ram_sel, io_hit, we;
    logic [2:0] io_a;
    assign ram_sel = ~bus.DA[15];
    assign io_hit  = bus.DA[15] & (bus.DA[14:3] == 12'd0);
    assign io_a    = bus.DA[2:0];
    assign we      = ~bus.RW & ~RST;

    logic wr_pout, wr_tcnt, wr_tstat, wr_utx;
    assign wr_pout  = we & io_hit & (io_a == 3'd0);
    assign wr_tcnt  = we & io_hit & (io_a == 3'd2);
    assign wr_tstat = we & io_hit & (io_a == 3'd3);
    assign wr_utx   = we & io_hit & (io_a == 3'd4);

    always_ff @(posedge CK) begin
        if (we && ram_sel) mem[bus.DA[AW-1:0]] <= DD;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            pout_q  <= 16'h0000;
            sync1_q <= 16'h0000;
            sync2_q <= 16'h0000;
            tcnt_q  <= 16'h0000;
            pre_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_pout) pout_q <= DD;
            sync1_q <= PIN;
            sync2_q <= sync1_q;
            tcnt_q  <= tcnt_d;
            pre_q   <= pre_d;
            ovf_q   <= ovf_d;
        end
    end

    // Timer: CPU load beats the increment; overflow set beats software clear
    logic pre_wrap;
    assign pre_wrap = (pre_q == PW'(TIMER_DIV - 1));

    always_comb begin
        pre_d  = pre_wrap ? '0 : pre_q + 1'b1;
        tcnt_d = tcnt_q + {15'd0, pre_wrap};
        ovf_d  = ovf_q;
        if (wr_tstat && DD[0]) ovf_d = 1'b0;
        if (pre_wrap && (tcnt_q == 16'hFFFF) && !wr_tcnt) ovf_d = 1'b1;
        if (wr_tcnt) begin
            tcnt_d = DD;
            pre_d  = '0;
        end
    end

    // UART state register
    always_ff @(posedge CK) begin
        if (RST) begin
            st_q  <= U_IDLE;
            cnt_q <= '0;
            bit_q <= 3'd0;
            sh_q  <= 8'h00;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
        end
    end

    // UART next state; a UTX write is only taken while IDLE
    logic tick;
    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        sh_d  = sh_q;
        unique case (st_q)
            U_IDLE: begin
                if (wr_utx) begin
                    st_d  = U_START;
                    cnt_d = '0;
                    sh_d  = DD[7:0];
                end
            end
            U_START: begin
                if (tick) begin
                    st_d  = U_DATA;
                    cnt_d = '0;
                    bit_d = 3'd0;
                end else cnt_d = cnt_q + 1'b1;
            end
            U_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) st_d = U_STOP;
                    else               bit_d = bit_q + 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            U_STOP: begin
                if (tick) begin
                    st_d  = U_IDLE;
                    cnt_d = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            default: st_d = U_IDLE;
        endcase
    end

    // UART outputs
    always_comb begin
        busy = (st_q != U_IDLE);
        unique case (st_q)
            U_START: TXD = 1'b0;
            U_DATA:  TXD = sh_q[0];
            default: TXD = 1'b1;
        endcase
    end

    always_comb begin
        rdata = 16'h0000;
        if (ram_sel) rdata = mem[bus.DA[AW-1:0]];
        else if (io_hit) begin
            case (io_a)
                3'd0:    rdata = pout_q;
                3'd1:    rdata = sync2_q;
                3'd2:    rdata = tcnt_q;
                3'd3:    rdata = {15'd0, ovf_q};
                3'd5:    rdata = {15'd0, busy};
                default: rdata = 16'h0000;
            endcase
        end
    end

    assign DD   = bus.RW ? rdata : 16'hzzzz;
    assign POUT = pout_q;
endmodule

// File: tb/tb_data_mem_io.sv
// Scoreboard bench: stimulus queues expected values, negedge monitor checks.
module tb_data_mem_io;
    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] PIN = 16'h0000;
    wire  [15:0] DD;
    logic [15:0] POUT;
    logic        TXD;
    logic [15:0] dd_drv = 16'h0000;
    logic        dd_oe = 1'b0;

    assign DD = dd_oe ? dd_drv : 16'hzzzz;

    data_mem_io_if bus();

    data_mem_io #(.AW(8), .TIMER_DIV(4), .CLKS_PER_BIT(16)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus),
        .DD  (DD),
        .PIN (PIN),
        .POUT(POUT),
        .TXD (TXD)
    );

    always #5 CK = ~CK;

    typedef struct {
        int          sel;   // 0 = DD, 1 = POUT, 2 = TXD
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    logic mon_req = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always @(negedge CK) begin
        if (mon_req) begin
            chk_t        c;
            logic [15:0] act;
            n_run++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: monitor found no expected entry");
            end else begin
                c = sb.pop_front();
                case (c.sel)
                    0:       act = DD;
                    1:       act = POUT;
                    default: act = {15'd0, TXD};
                endcase
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic expect_nxt(input int sel, input logic [15:0] e, input string nm);
        chk_t c;
        c.sel = sel; c.exp = e; c.name = nm;
        sb.push_back(c);
        mon_req = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        bus.DA = a; bus.RW = 1'b1; dd_oe = 1'b0;
        expect_nxt(0, e, nm);
        cyc();
        mon_req = 1'b0;
    endtask

    task automatic obs(input int sel, input logic [15:0] e, input string nm);
        expect_nxt(sel, e, nm);
        cyc();
        mon_req = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit chk, input string nm);
        bus.DA = a; bus.RW = 1'b0; dd_drv = d; dd_oe = 1'b1;
        if (chk) expect_nxt(0, d, nm);
        cyc();
        mon_req = 1'b0;
        bus.RW = 1'b1; dd_oe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        bus.DA = 16'h0000;
        bus.RW = 1'b1;

        // Reset state, and a store presented during reset is ignored
        idle(2);
        obs(1, 16'h0000, "rst_pout");
        obs(2, 16'h0001, "rst_txd");
        rd(16'h8005, 16'h0000, "rst_ustat");
        rd(16'h8003, 16'h0000, "rst_tstat");
        rd(16'h8002, 16'h0000, "rst_tcnt");
        wr(16'h8000, 16'hBEEF, 1'b0, "");
        obs(1, 16'h0000, "rst_store_ignored");
        RST = 1'b0;

        // RAM, aliasing, and no drive during the write cycle
        wr(16'h0005, 16'h1234, 1'b0, "");
        rd(16'h0005, 16'h1234, "ram_rd");
        rd(16'h0105, 16'h1234, "ram_alias");
        wr(16'h0005, 16'h0F0F, 1'b1, "ram_wr_no_drive");
        rd(16'h0005, 16'h0F0F, "ram_rd2");

        // Output latch and input synchroniser
        wr(16'h8000, 16'hA5A5, 1'b0, "");
        obs(1, 16'hA5A5, "pout_latch");
        rd(16'h8000, 16'hA5A5, "pout_rd");
        PIN = 16'h00FF;
        rd(16'h8001, 16'h0000, "pin_edge0");
        rd(16'h8001, 16'h0000, "pin_edge1");
        rd(16'h8001, 16'h00FF, "pin_edge2");

        // Unmapped addresses
        rd(16'h8006, 16'h0000, "unmapped_8006");
        rd(16'h9000, 16'h0000, "unmapped_9000");
        rd(16'h8008, 16'h0000, "unmapped_8008");
        wr(16'h8007, 16'hFFFF, 1'b0, "");
        wr(16'h8008, 16'h1234, 1'b0, "");
        obs(1, 16'hA5A5, "unmapped_store_pout");
        rd(16'h8003, 16'h0000, "unmapped_store_tstat");

        // Timer wrap, overflow, clear, and set-beats-clear
        wr(16'h8002, 16'hFFFE, 1'b0, "");
        idle(4);
        rd(16'h8002, 16'hFFFF, "tcnt_after4");
        idle(3);
        rd(16'h8002, 16'h0000, "tcnt_after8");
        rd(16'h8003, 16'h0001, "ovf_set");
        wr(16'h8003, 16'h0001, 1'b0, "");
        rd(16'h8003, 16'h0000, "ovf_clear");
        wr(16'h8002, 16'hFFFF, 1'b0, "");
        idle(3);
        wr(16'h8003, 16'h0001, 1'b0, "");
        rd(16'h8003, 16'h0001, "ovf_set_beats_clear");
        rd(16'h8002, 16'h0000, "tcnt_wrap2");

        // UART frame of 0x53, with a dropped write while busy
        fr = {1'b1, 8'h53, 1'b0};
        wr(16'h8004, 16'h0053, 1'b0, "");
        for (int i = 0; i < 160; i++) begin
            if (i == 50)       wr(16'h8004, 16'h00FF, 1'b0, "");
            else if (i == 80)  rd(16'h8005, 16'h0001, "ustat_busy_mid");
            else if (i == 159) rd(16'h8005, 16'h0001, "ustat_busy_last");
            else               obs(2, {15'd0, fr[i/16]}, $sformatf("txd_bit%0d", i/16));
        end
        rd(16'h8005, 16'h0000, "ustat_idle");
        for (int i = 0; i < 40; i++) obs(2, 16'h0001, "txd_no_second_frame");

        // Reset in the middle of a frame
        wr(16'h8000, 16'h1234, 1'b0, "");
        wr(16'h8004, 16'h0053, 1'b0, "");
        idle(49);
        obs(2, 16'h0000, "txd_before_rst");
        RST = 1'b1;
        cyc();
        obs(2, 16'h0001, "rst_mid_txd");
        rd(16'h8005, 16'h0000, "rst_mid_ustat");
        obs(1, 16'h0000, "rst_mid_pout");
        rd(16'h8002, 16'h0000, "rst_mid_tcnt");
        RST = 1'b0;
        idle(2);

        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory and memory-mapped I/O for the 16-bit four-stage CPU. Attaches directly to the CPU data port (DA, DD, RW): serves loads combinationally within the CPU's stage-2 cycle and commits stores on the clock edge that ends a write cycle. Also provides an output latch, a synchronised input port, a prescaled timer with a sticky overflow flag, and a byte-wide UART transmitter.

## Interface
- AW, 8: RAM address width; RAM depth is 2^AW words of 16 bits.
- TIMER_DIV, 4: clock cycles per timer increment; must be ≥1.
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be ≥2.

- CK  in  1  clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- DA  in  16  data address from the CPU.
- DD  inout  16  data bus. The block drives it when RW=1 and releases it (Z) when RW=0.
- RW  in  1  1 = read, 0 = write. The CPU holds RW=0 for exactly one cycle per store.
- PIN  in  16  external input port (asynchronous).
- POUT  out  16  output latch.
- TXD  out  1  UART serial output; idles at 1.

## Operation
- Address decode:
  - DA[15]=0 selects RAM word DA[AW-1:0]. Upper bits DA[14:AW] are ignored, so the RAM aliases.
  - DA[15]=1 selects I/O; only DA[2:0] is decoded, and DA[14:3] must be 0 for a hit.
- I/O map (reads of any unmapped address return 0x0000; writes to them are ignored):
  - 0x8000 POUT: read/write.
  - 0x8001 PIN: read-only; the value passes through a 2-flop synchroniser.
  - 0x8002 TCNT: read/write. A write loads the count and clears the prescaler.
  - 0x8003 TSTAT: bit0 = OVF. Writing with DD[0]=1 clears OVF.
  - 0x8004 UTX: write-only, reads 0. A write starts a frame with DD[7:0] if the UART is idle; the write is dropped if it is busy.
  - 0x8005 USTAT: bit0 = BUSY.
- Reads: DD = read data, purely combinational from DA, whenever RW=1. No read side effects.
- Writes: the selected register or RAM word is updated on the rising edge where RW=0, capturing DD at that edge.
- RAM is not reset; its contents are undefined until written.
- Timer:
  - A prescaler counts 0 to TIMER_DIV-1. When it wraps, TCNT increments.
  - TCNT wraps 0xFFFF→0x0000 and sets OVF on that wrap.
  - If the set and the software clear of OVF happen on the same edge, set wins.
  - If a CPU write to TCNT and an increment happen on the same edge, the write wins.
- UART transmit state machine: IDLE → START → DATA → STOP → IDLE.
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: TXD=1 for CLKS_PER_BIT cycles.
  - BUSY=1 in every state other than IDLE.

## Timing
- Reset values:
  - POUT=0x0000, TXD=1.
  - TCNT=0, prescaler=0, OVF=0.
  - UART in IDLE, BUSY=0.
  - Synchroniser flops = 0.
- While RST=1, any store presented is ignored, and the block still drives DD since RW=1.
- Reset mid-frame: TXD returns to 1 on the next edge and the frame is aborted.
- Load latency is 0 cycles: DD is valid in the same cycle DA is stable. The CPU captures it at the end of its stage-2 cycle.
- Store latency is 1 edge: a read of the same location in the following cycle returns the new value.
- PIN latency is 2 edges from a change on PIN to a change in the value read at 0x8001.
- UART timing:
  - The write edge moves the state machine to START, and TXD=0 from the next cycle.
  - A frame lasts exactly 10·CLKS_PER_BIT cycles.
  - BUSY falls on the edge that ends STOP.
  - A UTX write on the same edge that BUSY falls is dropped, because BUSY is sampled before the update.
- Timer: with TIMER_DIV=4, TCNT increments every 4th edge after reset release.

## Test plan
- RAM: store 0x1234 to 0x0005, then load 0x0005 → DD=0x1234. Load 0x0105 (AW=8, alias) → 0x1234. During the write cycle the block does not drive DD.
- POUT/PIN: store 0xA5A5 to 0x8000 → POUT=0xA5A5 after 1 edge, and reading 0x8000 returns 0xA5A5. Set PIN=0x00FF → reads of 0x8001 return 0x0000 for 2 edges, then 0x00FF.
- Timer: store 0xFFFE to 0x8002 (TIMER_DIV=4).
  - After 4 edges TCNT=0xFFFF; after 8 edges TCNT=0x0000 and TSTAT=0x0001.
  - Store 0x0001 to 0x8003 → TSTAT reads 0.
  - Clear coincident with a wrap → OVF stays 1.
- UART: store 0x0053 to 0x8004 (CLKS_PER_BIT=16).
  - TXD sequence is 0, 1,1,0,0,1,0,1,0, 1, each bit 16 cycles.
  - USTAT=1 for 160 cycles, then 0.
  - A second store during BUSY is dropped, so no second frame follows.
- Unmapped: reads of 0x8006 and 0x9000 return 0x0000; a store to 0x8007 changes no state.
- Reset mid-frame: assert RST during DATA → next edge TXD=1, USTAT=0, POUT=0, TCNT=0.
